// File: rtl/latch_load_seq_pkg.sv
// Shared definitions for latch-bank write sequencers: state encoding and sizing helpers.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package latch_load_seq_pkg;

    // Sequencer phase encoding; kept as plain constants so other controllers can reuse it.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Timer must hold the largest reload value (cycles-1) plus headroom; never wraps.
    function automatic int timer_width(input int s, input int p, input int h);
        return $clog2(max3(s, p, h) + 1);
    endfunction

endpackage

// File: rtl/latch_load_seq_phase_timer.sv
// Loadable down-counter with a zero flag, used to time each sequencer phase.
// Latency: load takes effect on the next edge; zero reflects the registered count.
// Backpressure: none; holds at zero until reloaded.
module phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/latch_load_seq.sv
// Write sequencer for a bank of level-sensitive latches: SETUP -> PULSE -> HOLD per write.
// Latency: En rises SETUP_CYC after accept, falls PULSE_CYC later; done SETUP+PULSE+HOLD after accept.
// Backpressure: in_ready only in IDLE; requests while busy are ignored and must be held upstream.
module latch_load_seq
    import latch_load_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NBANK     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NBANK)-1:0] in_addr,
    input  logic [WIDTH-1:0]         in_data,
    output logic [WIDTH-1:0]         D,
    output logic [NBANK-1:0]         En,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW = $clog2(NBANK);
    localparam int CW = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [AW-1:0]    addr_q;
    logic             accept;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_zero;
    logic             addr_bad;
    logic [NBANK-1:0] en_dec;

    // Only in_ready is combinational; everything toward the latches is registered.
    assign in_ready = (state == ST_IDLE) && !rst;
    assign accept   = in_ready && in_valid;

    // Addresses past the last bank run the full sequence with no enable.
    assign addr_bad = ({1'b0, addr_q} >= (AW + 1)'(NBANK));
    assign en_dec   = addr_bad ? '0 : (NBANK'(1) << addr_q);

    phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state and timer reload: each phase reloads the timer with its length minus one.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = CW'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_nxt = ST_PULSE;
                    tmr_load  = 1'b1;
                    tmr_val   = CW'(PULSE_CYC - 1);
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_nxt = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = CW'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, captured request and outputs; En is decoded from next-state so it is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            D      <= '0;
            En     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                D      <= in_data;
                addr_q <= in_addr;
            end
            En   <= (state_nxt == ST_PULSE) ? en_dec : '0;
            busy <= (state_nxt != ST_IDLE);
            done <= (state == ST_HOLD) && tmr_zero;
            err  <= (state == ST_HOLD) && tmr_zero && addr_bad;
        end
    end

endmodule

// File: tb/tb_latch_load_seq.sv
// Directed bench for latch_load_seq: three instances (default, slow timing, NBANK=3).
// Expected writes are queued at accept and retired when done is observed.
// Per-cycle invariants: one-hot En and D stable around any enable activity.
module tb_latch_load_seq;

    typedef struct {
        int         dut;
        int         t;
        logic [3:0] en;
        logic [7:0] data;
        logic       err;
    } exp_t;

    localparam int S_C [3] = '{1, 3, 1};
    localparam int P_C [3] = '{2, 1, 2};
    localparam int H_C [3] = '{1, 2, 1};
    localparam int NB_C[3] = '{4, 4, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld   [3];
    logic [1:0] adr   [3];
    logic [7:0] dat   [3];
    logic       rdy   [3];
    logic       busy_o[3];
    logic       done_o[3];
    logic       err_o [3];
    logic [7:0] d_o   [3];
    logic [3:0] en_o  [3];
    logic [2:0] en2;

    assign en_o[2] = {1'b0, en2};

    always #5 clk = ~clk;

    latch_load_seq u0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_addr(adr[0]),
        .in_data(dat[0]), .D(d_o[0]), .En(en_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    latch_load_seq #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_addr(adr[1]),
        .in_data(dat[1]), .D(d_o[1]), .En(en_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    latch_load_seq #(.NBANK(3)) u2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_addr(adr[2]),
        .in_data(dat[2]), .D(d_o[2]), .En(en2), .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2])
    );

    int         nvec = 0;
    int         nerr = 0;
    int         cyc  = 0;
    exp_t       sb[$];
    logic       rst_prev;
    logic [3:0] en_prev  [3];
    logic [7:0] d_prev   [3];
    logic [3:0] eseen    [3];
    int         pcnt     [3];
    int         efirst   [3];
    int         done_cyc [3];
    logic       last_acc [3];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s dut%0d cyc%0d: observed %0h expected %0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic clear_track(input int k);
        eseen[k]  = '0;
        pcnt[k]   = 0;
        efirst[k] = 0;
    endtask

    // One clock: log accepts into the scoreboard, check invariants, retire on done.
    task automatic step();
        logic acc[3];
        exp_t e;
        for (int k = 0; k < 3; k++) acc[k] = vld[k] && rdy[k];
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            last_acc[k] = acc[k];
            if (acc[k]) begin
                e.dut  = k;
                e.t    = cyc;
                e.data = dat[k];
                e.err  = (int'(adr[k]) >= NB_C[k]);
                e.en   = e.err ? 4'b0000 : (4'(1) << adr[k]);
                sb.push_back(e);
            end
            chk("en_onehot0", k, 32'($onehot0(en_o[k])), 32'd1);
            if (!rst && !rst_prev && (en_o[k] != 4'b0 || en_prev[k] != 4'b0))
                chk("d_stable", k, 32'(d_o[k]), 32'(d_prev[k]));
            if (en_o[k] != 4'b0) begin
                if (pcnt[k] == 0) efirst[k] = cyc;
                pcnt[k]++;
                eseen[k] |= en_o[k];
            end
            if (done_o[k]) begin
                done_cyc[k] = cyc;
                chk("sb_has_entry", k, 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_dut", k, 32'(k), 32'(e.dut));
                    chk("done_d", k, 32'(d_o[k]), 32'(e.data));
                    chk("done_err", k, 32'(err_o[k]), 32'(e.err));
                    chk("done_latency", k, 32'(cyc - e.t), 32'(S_C[k] + P_C[k] + H_C[k]));
                    chk("en_pattern", k, 32'(eseen[k]), 32'(e.en));
                    chk("en_width", k, 32'(pcnt[k]), (e.en != 4'b0) ? 32'(P_C[k]) : 32'd0);
                    if (e.en != 4'b0)
                        chk("en_rise", k, 32'(efirst[k] - e.t), 32'(S_C[k]));
                end
                clear_track(k);
            end
            en_prev[k] = en_o[k];
            d_prev[k]  = d_o[k];
        end
        rst_prev = rst;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_accept(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (last_acc[k]) break;
            chk("held_d", k, 32'(d_o[k]), 32'(d_prev[k]));
        end
        chk("accepted", k, 32'(last_acc[k]), 32'd1);
    endtask

    initial begin
        rst_prev = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; adr[k] = '0; dat[k] = '0;
            en_prev[k] = '0; d_prev[k] = '0; done_cyc[k] = 0; last_acc[k] = 1'b0;
            clear_track(k);
        end

        // Reset state
        drain(2);
        for (int k = 0; k < 3; k++) begin
            chk("rst_en", k, 32'(en_o[k]), 32'd0);
            chk("rst_d", k, 32'(d_o[k]), 32'd0);
            chk("rst_busy", k, 32'(busy_o[k]), 32'd0);
            chk("rst_done", k, 32'(done_o[k]), 32'd0);
            chk("rst_err", k, 32'(err_o[k]), 32'd0);
            chk("rst_rdy", k, 32'(rdy[k]), 32'd0);
        end
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) chk("rdy_after_rst", k, 32'(rdy[k]), 32'd1);

        // Single write, default timing
        vld[0] = 1'b1; adr[0] = 2'd1; dat[0] = 8'hA5;
        step();
        vld[0] = 1'b0;
        chk("w1_d", 0, 32'(d_o[0]), 32'hA5);
        chk("w1_busy", 0, 32'(busy_o[0]), 32'd1);
        chk("w1_en_setup", 0, 32'(en_o[0]), 32'd0);
        step();
        chk("w1_en_pulse", 0, 32'(en_o[0]), 32'b0010);
        drain(6);

        // Back-to-back with request held
        vld[0] = 1'b1; adr[0] = 2'd0; dat[0] = 8'hA5;
        step();
        adr[0] = 2'd3; dat[0] = 8'h3C;
        wait_accept(0, 10);
        chk("b2b_gap", 0, 32'(cyc - done_cyc[0]), 32'd1);
        chk("b2b_d", 0, 32'(d_o[0]), 32'h3C);
        vld[0] = 1'b0;
        drain(7);

        // Backpressure: request during busy must be ignored
        vld[0] = 1'b1; adr[0] = 2'd2; dat[0] = 8'h11;
        step();
        adr[0] = 2'd1; dat[0] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_d", 0, 32'(d_o[0]), 32'h11);
            chk("bp_busy", 0, 32'(busy_o[0]), 32'd1);
        end
        wait_accept(0, 10);
        chk("bp_new_d", 0, 32'(d_o[0]), 32'hFF);
        vld[0] = 1'b0;
        drain(7);

        // Reset mid-PULSE
        vld[0] = 1'b1; adr[0] = 2'd2; dat[0] = 8'h5A;
        step();
        vld[0] = 1'b0;
        step();
        chk("pre_rst_en", 0, 32'(en_o[0]), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en", 0, 32'(en_o[0]), 32'd0);
        chk("arst_d", 0, 32'(d_o[0]), 32'd0);
        chk("arst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("arst_rdy", 0, 32'(rdy[0]), 32'd0);
        sb.delete();
        clear_track(0);
        step();
        rst = 1'b0;
        step();
        chk("rdy_after_arst", 0, 32'(rdy[0]), 32'd1);
        chk("idle_after_arst", 0, 32'(busy_o[0]), 32'd0);

        // Slow timing instance: SETUP=3, PULSE=1, HOLD=2
        vld[1] = 1'b1; adr[1] = 2'd1; dat[1] = 8'h77;
        step();
        vld[1] = 1'b0;
        drain(2);
        chk("sw_en_setup", 1, 32'(en_o[1]), 32'd0);
        step();
        chk("sw_en_pulse", 1, 32'(en_o[1]), 32'b0010);
        drain(6);

        // NBANK=3: valid address then out-of-range address
        vld[2] = 1'b1; adr[2] = 2'd2; dat[2] = 8'h42;
        step();
        vld[2] = 1'b0;
        drain(6);
        vld[2] = 1'b1; adr[2] = 2'd3; dat[2] = 8'h99;
        step();
        vld[2] = 1'b0;
        drain(6);

        chk("sb_empty", 0, 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
